video_delay_line: RTL and testbench
===================================

VIDEO_DELAY_LINE -- requirements
Module: video_delay_line

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, bits per colour channel.
REQ-002 The block SHALL have parameter CHANNELS, default 3, colour channels per pixel, packed MSB-first (R,G,B).
REQ-003 The block SHALL have parameter MAX_DELAY, default 16, ring depth in pixels, a power of two >= 2.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset, with ports named as follows.
REQ-005 The block SHALL have port clk, input, 1, pixel clock.
REQ-006 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port delay_sel, input, AW=clog2(MAX_DELAY), requested extra delay d in pixels.
REQ-008 The block SHALL have ports in_de, in_hsync and in_vsync, input, 1 each, input video timing.
REQ-009 The block SHALL have port in_pixel, input, CHANNELS*DATA_WIDTH, input pixel.
REQ-010 The block SHALL have ports out_de, out_hsync and out_vsync, output, 1 each, delayed timing.
REQ-011 The block SHALL have port out_pixel, output, CHANNELS*DATA_WIDTH, delayed pixel.
REQ-012 The block SHALL have port out_valid, output, 1, high when outputs carry real delayed samples.
REQ-013 The block SHALL have port delay_active, output, AW, delay currently applied.

Function
REQ-014 The block SHALL write the word {in_de, in_hsync, in_vsync, in_pixel} into a MAX_DELAY-entry ring at wr_ptr on every edge, and wr_ptr SHALL increment modulo MAX_DELAY.
REQ-015 A sample captured at edge k SHALL appear on the registered outputs after edge k+delay_active: d=0 is a single register stage taken directly from the inputs, and d>0 reads ring[(wr_ptr-d) mod MAX_DELAY].
REQ-016 de, hsync, vsync and pixel SHALL travel in the same ring word so that all outputs stay mutually aligned for every d.
REQ-017 fill_cnt SHALL count edges since reset, saturating at MAX_DELAY-1.
REQ-018 The block SHALL implement a two-state FSM, PRIME and RUN: reset enters PRIME, and the FSM SHALL move PRIME->RUN on the edge where fill_cnt >= delay_active.
REQ-019 In PRIME, out_de, out_hsync, out_vsync, out_pixel and out_valid SHALL be forced to 0.
REQ-020 In RUN, out_valid SHALL be 1.
REQ-021 In RUN, an increase of delay_active SHALL NOT return the FSM to PRIME, because saturated fill_cnt guarantees the data is valid.
REQ-022 Pointer wrap SHALL be seamless: no gap, repeat or glitch at wr_ptr MAX_DELAY-1 -> 0.
REQ-023 Address arithmetic SHALL be unsigned AW-bit modulo; no other width extension is permitted.
REQ-024 Ring contents SHALL NOT be cleared, and stale data SHALL never reach the outputs because of PRIME gating.

Reset
REQ-025 When rst=1 at an edge, the block SHALL set wr_ptr=0, fill_cnt=0, state=PRIME, all outputs and out_valid to 0, and delay_active <= delay_sel.
REQ-026 Reset asserted mid-frame SHALL abort the stream immediately, with outputs 0 after that edge, and re-prime after release exactly as from power-up.
REQ-027 Reset SHALL take priority over every simultaneous event, including a vsync rising edge and a delay change.

Configuration
REQ-028 The block SHALL support the macro VIDEO_DELAY_LINE_FRAME_SYNC_EN.
REQ-029 With VIDEO_DELAY_LINE_FRAME_SYNC_EN defined, delay_active SHALL load delay_sel only on the edge where a rising edge of in_vsync is detected (in_vsync=1 and the registered previous in_vsync=0), so delay changes never tear a frame; a delay_sel change in that same cycle SHALL be captured.
REQ-030 Without VIDEO_DELAY_LINE_FRAME_SYNC_EN, delay_active SHALL load delay_sel on every edge, so a change takes effect on the next edge; samples are dropped on an increase and repeated on a decrease, which is the accepted behaviour.

Verification
REQ-031 Scenario 1 (defaults): d=0 and in_pixel=0x112233 with in_de=1 at edge 5 after reset release -> out_pixel=0x112233, out_de=1, out_valid=1 after edge 5.
REQ-032 Scenario 2: d=8 and in_pixel=edge index k -> outputs 0 and out_valid=0 for edges 0..7; out_pixel=k-8 from edge 8 onward.
REQ-033 Scenario 3: d=15, ramp input for 40 edges -> out_pixel=k-15 continuously across wr_ptr wraps at k=16 and k=32, with no discontinuity.
REQ-034 Scenario 4: hsync pulse edges 30..32 with de=0, d=6 -> out_hsync=1 exactly after edges 36..38, and out_de=0 in the same cycles.
REQ-035 Scenario 5: macro on, delay_sel changes 4->10 mid-frame -> delay_active stays 4 until the in_vsync rising edge, then reads 10; macro off, delay_active reads 10 on the next edge.
REQ-036 Scenario 6: d=5 with a running stream, rst=1 for one edge at edge 20 -> outputs 0 after edges 20..25, out_valid=1 and the correct data from edge 26.

Source files
------------

// File: rtl/video_delay_line.sv
// Video delay line: delays pixel data and timing (de/hsync/vsync) by 0..MAX_DELAY-1 pixels.
// Latency: one register stage plus delay_active pixels. No backpressure: one sample per clock.
// Optional macro VIDEO_DELAY_LINE_FRAME_SYNC_EN: delay changes are applied only at a rising edge of in_vsync.
module video_delay_line #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 3,
  parameter int MAX_DELAY  = 16,
  localparam int AW        = $clog2(MAX_DELAY)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [AW-1:0]                  delay_sel,
  input  logic                           in_de,
  input  logic                           in_hsync,
  input  logic                           in_vsync,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_pixel,
  output logic                           out_de,
  output logic                           out_hsync,
  output logic                           out_vsync,
  output logic [CHANNELS*DATA_WIDTH-1:0] out_pixel,
  output logic                           out_valid,
  output logic [AW-1:0]                  delay_active
);

  localparam int PW = CHANNELS * DATA_WIDTH;
  localparam int WW = PW + 3;
  localparam logic [AW-1:0] FILL_MAX = AW'(MAX_DELAY - 1);

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Timing and pixel travel together so they stay aligned for any delay.
  typedef struct packed {
    logic          de;
    logic          hsync;
    logic          vsync;
    logic [PW-1:0] pixel;
  } vid_word_t;

  vid_word_t       ring [MAX_DELAY];
  vid_word_t       in_word;
  vid_word_t       rd_word;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_addr;
  logic [AW-1:0]   fill_cnt;
  logic            vsync_prev;
  state_t          state;
  state_t          state_nxt;

  assign in_word = '{de: in_de, hsync: in_hsync, vsync: in_vsync, pixel: in_pixel};

  // Read address wraps naturally in AW bits because MAX_DELAY is a power of two.
  assign rd_addr = wr_ptr - delay_active;

  // Zero delay bypasses the ring; otherwise the word written delay_active edges ago.
  always_comb begin
    rd_word = in_word;
    if (delay_active != '0) begin
      rd_word = ring[rd_addr];
    end
  end

  // Ring write on every edge; contents are never cleared, PRIME gating hides stale entries.
  always_ff @(posedge clk) begin
    ring[wr_ptr] <= in_word;
  end

  // Write pointer advances every edge, wrapping modulo MAX_DELAY.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // Edges since reset, saturating once the whole ring holds live data.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt <= '0;
    end else if (fill_cnt != FILL_MAX) begin
      fill_cnt <= fill_cnt + 1'b1;
    end
  end

  // Previous vsync, used to detect the start of a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_prev <= 1'b0;
    end else begin
      vsync_prev <= in_vsync;
    end
  end

  // Applied delay: reset always loads the request; afterwards either per-frame or per-edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      delay_active <= delay_sel;
    end else begin
`ifdef VIDEO_DELAY_LINE_FRAME_SYNC_EN
      if (in_vsync && !vsync_prev) begin
        delay_active <= delay_sel;
      end
`else
      delay_active <= delay_sel;
`endif
    end
  end

  // FSM next state: leave PRIME once enough samples are buffered; RUN is sticky until reset.
  always_comb begin
    state_nxt = state;
    case (state)
      PRIME: begin
        if (fill_cnt >= delay_active) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        state_nxt = RUN;
      end
      default: begin
        state_nxt = PRIME;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PRIME;
    end else begin
      state <= state_nxt;
    end
  end

  // Registered outputs, forced to zero while priming so stale ring data never escapes.
  always_ff @(posedge clk) begin
    if (rst || (state_nxt == PRIME)) begin
      out_de    <= 1'b0;
      out_hsync <= 1'b0;
      out_vsync <= 1'b0;
      out_pixel <= '0;
      out_valid <= 1'b0;
    end else begin
      out_de    <= rd_word.de;
      out_hsync <= rd_word.hsync;
      out_vsync <= rd_word.vsync;
      out_pixel <= rd_word.pixel;
      out_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_video_delay_line.sv
// Testbench for video_delay_line: randomized and directed stimulus against a history-based model.
// The model keeps every sample since reset and picks the one delay_active edges back.
// Works with or without VIDEO_DELAY_LINE_FRAME_SYNC_EN defined.
module tb_video_delay_line;

  localparam int DW = 8;
  localparam int CH = 3;
  localparam int MD = 16;
  localparam int AW = 4;
  localparam int PW = DW * CH;
  localparam int WW = PW + 3;

  logic          clk;
  logic          rst;
  logic [AW-1:0] delay_sel;
  logic          in_de;
  logic          in_hsync;
  logic          in_vsync;
  logic [PW-1:0] in_pixel;
  logic          out_de;
  logic          out_hsync;
  logic          out_vsync;
  logic [PW-1:0] out_pixel;
  logic          out_valid;
  logic [AW-1:0] delay_active;

  int checks   = 0;
  int failures = 0;

  // Model state.
  int            e;
  bit            run;
  logic [AW-1:0] da;
  bit            vprev;
  logic [WW-1:0] hist [0:4095];
  logic [WW-1:0] exp_word;
  bit            exp_valid;

  video_delay_line #(
    .DATA_WIDTH(DW),
    .CHANNELS  (CH),
    .MAX_DELAY (MD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .delay_sel   (delay_sel),
    .in_de       (in_de),
    .in_hsync    (in_hsync),
    .in_vsync    (in_vsync),
    .in_pixel    (in_pixel),
    .out_de      (out_de),
    .out_hsync   (out_hsync),
    .out_vsync   (out_vsync),
    .out_pixel   (out_pixel),
    .out_valid   (out_valid),
    .delay_active(delay_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, obs, exp);
    end
  endtask

  // One clock edge: advance the model with the current inputs, then compare after the edge.
  task automatic step();
    logic [WW-1:0] w;
    int            fill;
    bit            nrun;
    @(posedge clk);
    w = {in_de, in_hsync, in_vsync, in_pixel};
    if (rst) begin
      e         = 0;
      run       = 0;
      da        = delay_sel;
      vprev     = 0;
      exp_word  = '0;
      exp_valid = 0;
    end else begin
      fill = (e < MD - 1) ? e : MD - 1;
      nrun = run || (fill >= int'(da));
      if (nrun) exp_word = (da == 0) ? w : hist[e - int'(da)];
      else      exp_word = '0;
      exp_valid = nrun;
      if (e < 4096) hist[e] = w;
      e++;
`ifdef VIDEO_DELAY_LINE_FRAME_SYNC_EN
      if (in_vsync && !vprev) da = delay_sel;
`else
      da = delay_sel;
`endif
      vprev = in_vsync;
      run   = nrun;
    end
    #1;
    chk("word", 64'({out_de, out_hsync, out_vsync, out_pixel}), 64'(exp_word));
    chk("valid", 64'(out_valid), 64'(exp_valid));
    chk("delay_active", 64'(delay_active), 64'(da));
  endtask

  task automatic set_in(input logic de, input logic hs, input logic vs, input logic [PW-1:0] pix);
    in_de    = de;
    in_hsync = hs;
    in_vsync = vs;
    in_pixel = pix;
  endtask

  task automatic do_reset(input logic [AW-1:0] d);
    rst       = 1'b1;
    delay_sel = d;
    set_in(1'b1, 1'b1, 1'b1, PW'($urandom));
    step();
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_pixel", 64'(out_pixel), 64'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    delay_sel = '0;
    set_in(1'b0, 1'b0, 1'b0, '0);
    e = 0; run = 0; da = '0; vprev = 0;
    #2;

    // d=0: pixel at edge 5 appears right after edge 5.
    do_reset(4'd0);
    for (int k = 0; k < 10; k++) begin
      set_in(k == 5, 1'b0, 1'b0, (k == 5) ? 24'h112233 : PW'($urandom));
      step();
      if (k == 5) begin
        chk("s1_pixel", 64'(out_pixel), 64'h112233);
        chk("s1_de", 64'(out_de), 64'd1);
        chk("s1_valid", 64'(out_valid), 64'd1);
      end
    end

    // d=8 ramp: blank for edges 0..7, k-8 afterwards.
    do_reset(4'd8);
    for (int k = 0; k < 20; k++) begin
      set_in(1'b1, 1'b0, 1'b0, PW'(k));
      step();
      if (k == 7) chk("s2_prime", 64'(out_valid), 64'd0);
      if (k == 8) chk("s2_first", 64'(out_pixel), 64'd0);
      if (k == 12) chk("s2_mid", 64'(out_pixel), 64'd4);
    end

    // d=15 ramp across two pointer wraps.
    do_reset(4'd15);
    for (int k = 0; k < 40; k++) begin
      set_in(1'b1, 1'b0, 1'b0, PW'(k));
      step();
      if (k >= 15) chk("s3_ramp", 64'(out_pixel), 64'(k - 15));
    end

    // d=6: hsync pulse at edges 30..32 with de low.
    do_reset(4'd6);
    for (int k = 0; k < 45; k++) begin
      set_in(!(k >= 30 && k <= 32), (k >= 30 && k <= 32), 1'b0, PW'($urandom));
      step();
      if (k >= 36 && k <= 38) begin
        chk("s4_hsync", 64'(out_hsync), 64'd1);
        chk("s4_de", 64'(out_de), 64'd0);
      end
      if (k == 35 || k == 39) chk("s4_hsync_edge", 64'(out_hsync), 64'd0);
    end

    // Delay change 4 -> 10 mid-frame, then a vsync rising edge.
    do_reset(4'd4);
    for (int k = 0; k < 20; k++) begin
      set_in(1'b1, 1'b0, 1'b0, PW'($urandom));
      step();
    end
    delay_sel = 4'd10;
    step();
`ifdef VIDEO_DELAY_LINE_FRAME_SYNC_EN
    chk("s5_hold", 64'(delay_active), 64'd4);
`else
    chk("s5_next", 64'(delay_active), 64'd10);
`endif
    for (int k = 0; k < 3; k++) step();
    set_in(1'b0, 1'b0, 1'b1, PW'($urandom));
    step();
    chk("s5_vsync", 64'(delay_active), 64'd10);
    for (int k = 0; k < 12; k++) begin
      set_in(1'b1, 1'b0, 1'b0, PW'($urandom));
      step();
    end

    // d=5 stream with a one-edge reset at edge 20.
    do_reset(4'd5);
    for (int k = 0; k < 40; k++) begin
      rst = (k == 20);
      set_in(1'b1, 1'b0, 1'b0, PW'(k));
      step();
      if (k == 25) chk("s6_prime", 64'(out_valid), 64'd0);
      if (k == 26) begin
        chk("s6_valid", 64'(out_valid), 64'd1);
        chk("s6_pixel", 64'(out_pixel), 64'd21);
      end
    end
    rst = 1'b0;

    // Randomized segments: random timing/pixels, occasional delay changes and resets.
    for (int seg = 0; seg < 8; seg++) begin
      do_reset(AW'($urandom_range(0, MD - 1)));
      for (int k = 0; k < 150; k++) begin
        rst = ($urandom_range(0, 99) == 0);
        if (!rst && e >= MD && $urandom_range(0, 19) == 0)
          delay_sel = AW'($urandom_range(0, MD - 1));
        set_in($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
               $urandom_range(0, 7) == 0, PW'($urandom));
        step();
      end
      rst = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
